// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream bundle for maxpool2x2_stream: the input beat and the pooled output beat.
// The slave modport is the pooling block. The master modport is whoever feeds it and
// consumes its output.
interface maxpool2x2_stream_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_out;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  frame_done;

  modport slave (
    input  valid_in,
    input  data_in,
    output valid_out,
    output data_out,
    output frame_done
  );

  modport master (
    output valid_in,
    output data_in,
    input  valid_out,
    input  data_out,
    input  frame_done
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 max-pool over a row-major float32 pixel stream.
// An even row folds each pixel pair into a half-width line buffer of partial maxima.
// The odd row that follows finishes each window: one pooled pixel comes out one cycle
// after the bottom-right pixel of its window.
// Optional feature, macro MAXPOOL_RELU_EN: clamp inputs that have the sign bit set
// (this includes -0) to +0 before pooling.
module maxpool2x2_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WIDTH      = 56,
  parameter int unsigned HEIGHT     = 56
) (
  input  logic                    clk,
  input  logic                    rst,
  maxpool2x2_stream_if.slave      bus_io
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned CW   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned RW   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned BW   = (HALF   > 1) ? $clog2(HALF)   : 1;
  localparam int unsigned MSB  = DATA_WIDTH - 1;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] linebuf_q [HALF];
  logic [DATA_WIDTH-1:0] pix_c;
  logic [DATA_WIDTH-1:0] lb_rd_c;
  logic [DATA_WIDTH-1:0] lb_wdata_c;
  logic [BW-1:0]         lb_idx_c;
  logic                  lb_we_c;

  // Sign-magnitude max. Ties and +0/-0 return the first operand. NaN and Inf are not
  // special-cased; they compare as plain bit patterns.
  function automatic logic [DATA_WIDTH-1:0] fmax(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [MSB-1:0] ma;
    logic [MSB-1:0] mb;
    ma = a[MSB-1:0];
    mb = b[MSB-1:0];
    if (a[MSB] != b[MSB]) begin
      if ((ma == '0) && (mb == '0)) fmax = a;
      else                          fmax = a[MSB] ? b : a;
    end else if (!a[MSB]) begin
      fmax = (mb > ma) ? b : a;
    end else begin
      fmax = (mb < ma) ? b : a;
    end
  endfunction

  // Input conditioning: optional ReLU clamp ahead of the pooling datapath.
`ifdef MAXPOOL_RELU_EN
  always_comb pix_c = bus_io.data_in[MSB] ? '0 : bus_io.data_in;
`else
  always_comb pix_c = bus_io.data_in;
`endif

  // Line buffer read for the column pair of the current beat.
  always_comb begin
    lb_idx_c = BW'(col_q >> 1);
    lb_rd_c  = linebuf_q[lb_idx_c];
  end

  // Next-state: raster counters and the window fold selected by row/col parity.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    pair_d     = pair_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    done_d     = 1'b0;
    lb_we_c    = 1'b0;
    lb_wdata_c = fmax(pair_q, pix_c);
    if (bus_io.valid_in) begin
      if (col_q == CW'(WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      case ({row_q[0], col_q[0]})
        2'b00: pair_d  = pix_c;
        2'b01: lb_we_c = 1'b1;
        2'b10: pair_d  = fmax(lb_rd_c, pix_c);
        2'b11: begin
          data_d  = fmax(pair_q, pix_c);
          valid_d = 1'b1;
          done_d  = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Line buffer of partial maxima. It has no reset because every entry is written in
  // an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (lb_we_c) linebuf_q[lb_idx_c] <= lb_wdata_c;
  end

  assign bus_io.valid_out  = valid_q;
  assign bus_io.data_out   = data_q;
  assign bus_io.frame_done = done_q;

endmodule
